// File: rtl/vfifo_wr_ctrl.sv
// rtl/vfifo_wr_ctrl.sv - write-side control stage of the dual-clock FIFO
//
// Purpose:
//   Accepts producer words over a valid/ready handshake and drives the
//   write port of the dual-port RAM. Keeps the binary and Gray write
//   pointers. Brings the read-side Gray pointer into the write clock
//   domain through a two-flop synchroniser, and derives full and fill
//   level from it. Everything runs in the clk domain.
//
// Optional feature:
//   VFIFO_WR_AFULL_EN - when defined, afull is a registered almost-full
//   flag (fill including this cycle's accept >= AFULL_LEVEL). When it is
//   undefined, afull is tied low and no extra flops are built.
//
// Ports:
//   clk        in   write-domain clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_data    in   producer data word
//   wr_valid   in   producer has a word
//   wr_ready   out  FIFO can accept (~full)
//   ram_d      out  RAM write data (wr_data pass-through)
//   ram_adr    out  RAM write address (low bits of the binary write pointer)
//   ram_we     out  RAM write enable (accept)
//   rptr_gray  in   Gray read pointer from the read domain (asynchronous)
//   wptr_gray  out  registered Gray write pointer, to the read domain
//   full       out  registered full flag
//   fill       out  words held, as seen from the write domain
//   afull      out  almost-full flag (optional feature, else 0)
//
// ADDR_WIDTH must be at least 2.

module vfifo_wr_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 9,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic                  ram_we,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  afull
);

  localparam int AW = ADDR_WIDTH;

  // Pointers carry one extra bit beyond the address so that a full FIFO
  // and an empty FIFO are distinguishable.
  typedef logic [AW:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  ptr_t wbin_q;
  ptr_t wbin_d;
  ptr_t wgray_q;
  ptr_t wgray_d;
  ptr_t rq1_q;
  ptr_t rq2_q;
  ptr_t rbin_sync;
  ptr_t full_match;
  logic full_q;
  logic full_d;
  logic accept;

  // The accept decision always uses the registered full flag, so a read
  // pointer arriving in the same cycle only matters from the next edge on.
  assign accept    = wr_valid & ~full_q;
  assign wbin_d    = wbin_q + {{AW{1'b0}}, accept};
  assign wgray_d   = bin2gray(wbin_d);
  assign rbin_sync = gray2bin(rq2_q);

  // In Gray code, "write is one lap ahead of read" means the two MSBs are
  // inverted and all lower bits are equal.
  assign full_match = {~rq2_q[AW:AW-1], rq2_q[AW-2:0]};
  assign full_d     = (wgray_d == full_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  // Plain two-flop synchroniser; nothing may sit between the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= rptr_gray;
      rq2_q <= rq1_q;
    end
  end

  assign wr_ready  = ~full_q;
  assign ram_we    = accept;
  assign ram_d     = wr_data;
  assign ram_adr   = wbin_q[AW-1:0];
  assign wptr_gray = wgray_q;
  assign full      = full_q;

  // Modulo subtraction is correct across wraps because the read pointer
  // is never ahead of the write pointer.
  assign fill = wbin_q - rbin_sync;

`ifdef VFIFO_WR_AFULL_EN
  localparam ptr_t AFULL_LVL = ptr_t'(AFULL_LEVEL);

  ptr_t fill_next;
  logic afull_q;

  assign fill_next = wbin_d - rbin_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (fill_next >= AFULL_LVL);
    end
  end

  assign afull = afull_q;
`else
  assign afull = 1'b0;
`endif

endmodule
